// File: rtl/boot_mem_arbiter_if.sv
// CPU-side and RAM-side bus bundle of the boot memory arbiter.
// The master modport is the arbiter's view; slave is the CPU/RAM side.
interface boot_mem_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [7:0]        cpu_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [7:0]        mem_rdata;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rvalid, mem_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rvalid, mem_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/boot_mem_arbiter.sv
// Owns the program-RAM port: drains loader bytes through a FIFO while the CPU
// is held in reset, waits a settle delay, then releases the CPU and grants it the port.
module boot_mem_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int FIFO_DEPTH    = 8,
   parameter int RELEASE_DELAY = 256
) (
   input  logic              clk_74a,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              load_done,
   input  logic              ld_wr_en,
   input  logic [ADDR_W-1:0] ld_wr_addr,
   input  logic [7:0]        ld_wr_data,
   boot_mem_arbiter_if.master bus,
   output logic              cpu_reset_n,
   output logic              busy,
   output logic              overflow
);

   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(RELEASE_DELAY + 1);

   typedef enum logic [2:0] {
      ST_WAIT_LOAD = 3'd0,
      ST_LOADING   = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_DELAY     = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
   logic [7:0]        fifo_data_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic              mem_en_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [7:0]        mem_wdata_r;
   logic              cpu_reset_n_r;
   logic              busy_r;
   logic              overflow_r;

   logic fifo_empty_s;
   logic fifo_full_s;
   logic fill_state_s;
   logic port_free_s;
   logic pop_s;
   logic push_req_s;
   logic push_s;
   logic drop_s;
   logic gnt_s;

   assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
   assign fifo_full_s  = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                         (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
   assign fill_state_s = (state_r == ST_LOADING) || (state_r == ST_DRAIN);
   assign port_free_s  = !mem_en_r || bus.mem_ready;
   assign pop_s        = fill_state_s && !fifo_empty_s && port_free_s;
   assign push_req_s   = fill_state_s && ld_wr_en;
   assign push_s       = push_req_s && (!fifo_full_s || pop_s);
   assign drop_s       = push_req_s && fifo_full_s && !pop_s;
   assign gnt_s        = (state_r == ST_RUN) && bus.cpu_req && port_free_s;

   // Next-state logic; load_start overrides everything else.
   always_comb begin
      state_s = state_r;
      if (load_start) begin
         state_s = ST_LOADING;
      end else begin
         case (state_r)
            ST_LOADING: begin
               if (load_done) state_s = ST_DRAIN;
               else           state_s = ST_LOADING;
            end
            // A byte arriving on the exit cycle keeps us draining so it is not stranded.
            ST_DRAIN: begin
               if (fifo_empty_s && !mem_en_r && !push_s) state_s = ST_DELAY;
               else                                      state_s = ST_DRAIN;
            end
            ST_DELAY: begin
               if (cnt_r == {CNT_W{1'b0}}) state_s = ST_RUN;
               else                        state_s = ST_DELAY;
            end
            ST_WAIT_LOAD: state_s = ST_WAIT_LOAD;
            ST_RUN:       state_s = ST_RUN;
            default:      state_s = ST_WAIT_LOAD;
         endcase
      end
   end

   // State register and registered status outputs.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_WAIT_LOAD;
         cpu_reset_n_r <= 1'b0;
         busy_r        <= 1'b1;
         overflow_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         cpu_reset_n_r <= (state_s == ST_RUN);
         busy_r        <= (state_s != ST_RUN);
         if (load_start)  overflow_r <= 1'b0;
         else if (drop_s) overflow_r <= 1'b1;
         else             overflow_r <= overflow_r;
      end
   end

   // Settle-delay counter.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_DRAIN) && (state_s == ST_DELAY)) begin
         cnt_r <= CNT_W'(RELEASE_DELAY - 1);
      end else if ((state_r == ST_DELAY) && (state_s == ST_DELAY)) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // FIFO pointers; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         else        wr_ptr_r <= wr_ptr_r;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         else        rd_ptr_r <= rd_ptr_r;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk_74a) begin
      if (push_s) begin
         fifo_addr_r[wr_ptr_r[IDX_W-1:0]] <= ld_wr_addr;
         fifo_data_r[wr_ptr_r[IDX_W-1:0]] <= ld_wr_data;
      end
   end

   // RAM port register: load from FIFO or CPU when free, else hold.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= 8'h00;
      end else if (pop_s) begin
         mem_en_r    <= 1'b1;
         mem_we_r    <= 1'b1;
         mem_addr_r  <= fifo_addr_r[rd_ptr_r[IDX_W-1:0]];
         mem_wdata_r <= fifo_data_r[rd_ptr_r[IDX_W-1:0]];
      end else if (gnt_s) begin
         mem_en_r    <= 1'b1;
         mem_we_r    <= bus.cpu_we;
         mem_addr_r  <= bus.cpu_addr;
         mem_wdata_r <= bus.cpu_wdata;
      end else if (port_free_s) begin
         mem_en_r    <= 1'b0;
      end else begin
         mem_en_r    <= mem_en_r;
      end
   end

   assign bus.mem_en     = mem_en_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.cpu_gnt    = gnt_s;
   assign bus.cpu_rvalid = bus.mem_rvalid && (state_r == ST_RUN);
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign cpu_reset_n    = cpu_reset_n_r;
   assign busy           = busy_r;
   assign overflow       = overflow_r;

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed self-checking bench for boot_mem_arbiter (RELEASE_DELAY=4, FIFO_DEPTH=8).
module tb_boot_mem_arbiter;

   logic        clk_74a;
   logic        reset_n;
   logic        load_start;
   logic        load_done;
   logic        ld_wr_en;
   logic [15:0] ld_wr_addr;
   logic [7:0]  ld_wr_data;
   logic        cpu_reset_n;
   logic        busy;
   logic        overflow;

   int tests_run;
   int tests_failed;

   logic [15:0] log_addr [$];
   logic [7:0]  log_data [$];

   boot_mem_arbiter_if #(.ADDR_W(16)) bus ();

   boot_mem_arbiter #(
      .ADDR_W       (16),
      .FIFO_DEPTH   (8),
      .RELEASE_DELAY(4)
   ) dut (
      .clk_74a    (clk_74a),
      .reset_n    (reset_n),
      .load_start (load_start),
      .load_done  (load_done),
      .ld_wr_en   (ld_wr_en),
      .ld_wr_addr (ld_wr_addr),
      .ld_wr_data (ld_wr_data),
      .bus        (bus),
      .cpu_reset_n(cpu_reset_n),
      .busy       (busy),
      .overflow   (overflow)
   );

   initial clk_74a = 1'b0;
   always #5 clk_74a = ~clk_74a;

   // RAM model: record every accepted write.
   always @(posedge clk_74a) begin
      if (bus.mem_en && bus.mem_ready && bus.mem_we) begin
         log_addr.push_back(bus.mem_addr);
         log_data.push_back(bus.mem_wdata);
      end
   end

   task automatic tick();
      @(posedge clk_74a);
      #1;
   endtask

   task automatic wait_run(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (cpu_reset_n === 1'b1) break;
         tick();
      end
   endtask

   // Grant and stall a CPU write so the port register stays occupied.
   task automatic stall_cpu_write(input logic [15:0] a, input logic [7:0] d);
      bus.mem_ready = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
      tick();
      bus.cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      tests_run++;
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0000 ||
          bus.mem_wdata !== 8'h00 || bus.cpu_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_port: en=%b we=%b addr=%h wdata=%h gnt=%b rvalid=%b, required all 0",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_gnt, bus.cpu_rvalid);
      end
      reset_n = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         tick();
         tests_run++;
         if (cpu_reset_n !== 1'b0 || busy !== 1'b1 || bus.mem_en !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle cyc=%0d: cpu_reset_n=%b busy=%b mem_en=%b overflow=%b, required 0 1 0 0",
                     c, cpu_reset_n, busy, bus.mem_en, overflow);
         end
      end
   endtask

   task automatic test_load();
      logic [15:0] ea [3] = '{16'h0000, 16'h0001, 16'h0002};
      logic [7:0]  ed [3] = '{8'h13, 8'h05, 8'hA0};
      int base;
      base = log_addr.size();
      bus.mem_ready = 1'b1;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_wr_en = 1'b1; ld_wr_addr = ea[i]; ld_wr_data = ed[i];
         tick();
      end
      ld_wr_en = 1'b0;
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      // Last write accepted 1 edge later, DELAY entered 2 edges later, release 4 after that.
      repeat (5) tick();
      tests_run++;
      if (cpu_reset_n !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_pre_release: cpu_reset_n=%b busy=%b, required 0 1", cpu_reset_n, busy);
      end
      tick();
      tests_run++;
      if (cpu_reset_n !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_release: cpu_reset_n=%b busy=%b, required 1 0", cpu_reset_n, busy);
      end
      tests_run++;
      if (log_addr.size() !== base + 3) begin
         tests_failed++;
         $display("FAIL load_count: writes=%0d, required %0d", log_addr.size() - base, 3);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (log_addr[base+i] !== ea[i] || log_data[base+i] !== ed[i]) begin
               tests_failed++;
               $display("FAIL load_write%0d: got %h/%h, required %h/%h",
                        i, log_addr[base+i], log_data[base+i], ea[i], ed[i]);
            end
         end
      end
   endtask

   task automatic test_cpu_access();
      int base;
      bus.mem_ready = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0002; bus.cpu_wdata = 8'h00;
      #1;
      tests_run++;
      if (bus.cpu_gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL cpu_read_gnt: gnt=%b, required 1", bus.cpu_gnt);
      end
      tick();
      bus.cpu_req = 1'b0;
      tests_run++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0002) begin
         tests_failed++;
         $display("FAIL cpu_read_req: en=%b we=%b addr=%h, required 1 0 0002",
                  bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'hA0;
      #1;
      tests_run++;
      if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA0) begin
         tests_failed++;
         $display("FAIL cpu_rdata: rvalid=%b rdata=%h, required 1 a0", bus.cpu_rvalid, bus.cpu_rdata);
      end
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00;
      tests_run++;
      if (bus.mem_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL cpu_deassert: mem_en=%b, required 0", bus.mem_en);
      end
      stall_cpu_write(16'h1234, 8'h5A);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (bus.cpu_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
             bus.mem_addr !== 16'h1234 || bus.mem_wdata !== 8'h5A) begin
            tests_failed++;
            $display("FAIL cpu_stall%0d: gnt=%b en=%b we=%b addr=%h wdata=%h, required 0 1 1 1234 5a",
                     i, bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
         end
         tick();
      end
      bus.cpu_req = 1'b0;
      base = log_addr.size();
      bus.mem_ready = 1'b1;
      tick();
      tests_run++;
      if (log_addr.size() !== base + 1 || bus.mem_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL cpu_write_done: writes=%0d mem_en=%b, required 1 0", log_addr.size() - base, bus.mem_en);
      end else if (log_addr[base] !== 16'h1234 || log_data[base] !== 8'h5A) begin
         tests_failed++;
         $display("FAIL cpu_write_data: got %h/%h, required 1234/5a", log_addr[base], log_data[base]);
      end
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      tick();
      tests_run++;
      if (busy !== 1'b0 || cpu_reset_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL stray_load_done: busy=%b cpu_reset_n=%b, required 0 1", busy, cpu_reset_n);
      end
   endtask

   task automatic test_reload();
      int base;
      base = log_addr.size();
      stall_cpu_write(16'h0100, 8'h77);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      tests_run++;
      if (cpu_reset_n !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reload_reset: cpu_reset_n=%b busy=%b, required 0 1", cpu_reset_n, busy);
      end
      ld_wr_en = 1'b1; ld_wr_addr = 16'h0010; ld_wr_data = 8'h11;
      tick();
      ld_wr_en = 1'b0;
      tick();
      tests_run++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 8'h77) begin
         tests_failed++;
         $display("FAIL reload_hold: en=%b addr=%h wdata=%h, required 1 0100 77",
                  bus.mem_en, bus.mem_addr, bus.mem_wdata);
      end
      bus.mem_ready = 1'b1;
      tick();
      tests_run++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 8'h11) begin
         tests_failed++;
         $display("FAIL reload_pop: en=%b we=%b addr=%h wdata=%h, required 1 1 0010 11",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      wait_run(30);
      tests_run++;
      if (cpu_reset_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL reload_release: cpu_reset_n=%b after budget, required 1", cpu_reset_n);
      end
      tests_run++;
      if (log_addr.size() !== base + 2) begin
         tests_failed++;
         $display("FAIL reload_count: writes=%0d, required 2", log_addr.size() - base);
      end else if (log_addr[base] !== 16'h0100 || log_data[base] !== 8'h77 ||
                   log_addr[base+1] !== 16'h0010 || log_data[base+1] !== 8'h11) begin
         tests_failed++;
         $display("FAIL reload_order: got %h/%h %h/%h, required 0100/77 0010/11",
                  log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]);
      end
   endtask

   task automatic test_overflow();
      int base;
      base = log_addr.size();
      stall_cpu_write(16'h0300, 8'h99);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         ld_wr_en = 1'b1; ld_wr_addr = 16'h0200 + 16'(i); ld_wr_data = 8'h30 + 8'(i);
         tick();
         if (i == 7) begin
            tests_run++;
            if (overflow !== 1'b0) begin
               tests_failed++;
               $display("FAIL ovf_at_full: overflow=%b, required 0", overflow);
            end
         end
      end
      ld_wr_en = 1'b0;
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_set: overflow=%b, required 1", overflow);
      end
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      bus.mem_ready = 1'b1;
      wait_run(60);
      tests_run++;
      if (cpu_reset_n !== 1'b1 || overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_release: cpu_reset_n=%b overflow=%b, required 1 1", cpu_reset_n, overflow);
      end
      tests_run++;
      if (log_addr.size() !== base + 9) begin
         tests_failed++;
         $display("FAIL ovf_count: writes=%0d, required 9", log_addr.size() - base);
      end else begin
         tests_run++;
         if (log_addr[base] !== 16'h0300 || log_data[base] !== 8'h99) begin
            tests_failed++;
            $display("FAIL ovf_cpu_first: got %h/%h, required 0300/99", log_addr[base], log_data[base]);
         end
         for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (log_addr[base+1+i] !== 16'h0200 + 16'(i) || log_data[base+1+i] !== 8'h30 + 8'(i)) begin
               tests_failed++;
               $display("FAIL ovf_write%0d: got %h/%h, required %h/%h", i, log_addr[base+1+i],
                        log_data[base+1+i], 16'h0200 + 16'(i), 8'h30 + 8'(i));
            end
         end
      end
      // load_start together with load_done: start wins, so no release without a later load_done.
      load_start = 1'b1; load_done = 1'b1;
      tick();
      load_start = 1'b0; load_done = 1'b0;
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
      end
      repeat (10) tick();
      tests_run++;
      if (busy !== 1'b1 || cpu_reset_n !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_wins: busy=%b cpu_reset_n=%b, required 1 0", busy, cpu_reset_n);
      end
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      wait_run(30);
      tests_run++;
      if (cpu_reset_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_reload_release: cpu_reset_n=%b, required 1", cpu_reset_n);
      end
   endtask

   task automatic test_async_reset();
      int base;
      stall_cpu_write(16'h0500, 8'h42);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_wr_en = 1'b1; ld_wr_addr = 16'h0400 + 16'(i); ld_wr_data = 8'h60 + 8'(i);
         tick();
      end
      ld_wr_en = 1'b0;
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      base = log_addr.size();
      bus.cpu_req = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0000 ||
          busy !== 1'b1 || cpu_reset_n !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_now: en=%b we=%b addr=%h busy=%b cpu_reset_n=%b gnt=%b, required 0 0 0000 1 0 0",
                  bus.mem_en, bus.mem_we, bus.mem_addr, busy, cpu_reset_n, bus.cpu_gnt);
      end
      #2 reset_n = 1'b1;
      bus.cpu_req = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (50) tick();
      tests_run++;
      if (log_addr.size() !== base || bus.mem_en !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL areset_quiet: writes=%0d mem_en=%b busy=%b, required 0 0 1",
                  log_addr.size() - base, bus.mem_en, busy);
      end
      // An empty load must produce no writes if the FIFO really was flushed.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      wait_run(30);
      tests_run++;
      if (cpu_reset_n !== 1'b1 || log_addr.size() !== base) begin
         tests_failed++;
         $display("FAIL areset_flushed: cpu_reset_n=%b writes=%0d, required 1 0",
                  cpu_reset_n, log_addr.size() - base);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset_n = 1'b0;
      load_start = 1'b0; load_done = 1'b0;
      ld_wr_en = 1'b0; ld_wr_addr = 16'h0000; ld_wr_data = 8'h00;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
      bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00;
      test_reset();
      test_load();
      test_cpu_access();
      test_reload();
      test_overflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
